// File: rtl/crc_lfsr_engine.sv
// Serial bit-at-a-time CRC LFSR with data-CRC snapshot and received-CRC residue check.
// Default parameters give the CAN CRC-15; CAN FD widths are reached by overriding CRC_W/POLY.
module crc_lfsr_engine #(
    parameter int unsigned      CRC_W = 15,
    parameter logic [CRC_W-1:0] POLY  = 15'h4599,
    parameter logic [CRC_W-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             crc_clr,
    input  logic             crc_en,
    input  logic             chk_en,
    output logic [CRC_W-1:0] crc,
    output logic             crc_valid,
    output logic             chk_done,
    output logic             crc_err
);

    localparam int unsigned     CntW    = $clog2(CRC_W + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(CRC_W - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StCheck, StDone} state_e;

    state_e           state_q, state_d;
    logic [CRC_W-1:0] lfsr_q, lfsr_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic             crc_valid_q, crc_valid_d;
    logic             chk_done_q, chk_done_d;
    logic             crc_err_q, crc_err_d;
    logic             data_seen_q, data_seen_d;
    logic [CntW-1:0]  chk_cnt_q, chk_cnt_d;

    logic             fb;
    logic [CRC_W-1:0] lfsr_shift;

    assign fb         = din ^ lfsr_q[CRC_W-1];
    assign lfsr_shift = {lfsr_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        crc_d       = crc_q;
        crc_valid_d = crc_valid_q;
        chk_done_d  = 1'b0;
        crc_err_d   = crc_err_q;
        data_seen_d = data_seen_q;
        chk_cnt_d   = chk_cnt_q;

        // A clear wins in every state; the crc output itself is left as last snapshotted.
        if (crc_clr) begin
            state_d     = StCalc;
            lfsr_d      = INIT;
            crc_valid_d = 1'b0;
            crc_err_d   = 1'b0;
            data_seen_d = 1'b0;
            chk_cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StCalc: begin
                    if (chk_en) begin
                        if (!crc_valid_q) begin
                            crc_d       = lfsr_q;
                            crc_valid_d = 1'b1;
                        end
                        lfsr_d    = lfsr_shift;
                        chk_cnt_d = CntW'(1);
                        state_d   = StCheck;
                    end else if (crc_en) begin
                        lfsr_d      = lfsr_shift;
                        data_seen_d = 1'b1;
                    end else if (data_seen_q && !crc_valid_q) begin
                        crc_d       = lfsr_q;
                        crc_valid_d = 1'b1;
                    end
                end
                StCheck: begin
                    if (chk_en) begin
                        lfsr_d    = lfsr_shift;
                        chk_cnt_d = chk_cnt_q + CntW'(1);
                        if (chk_cnt_q == CntLast) begin
                            chk_done_d = 1'b1;
                            crc_err_d  = (lfsr_shift != '0);
                            state_d    = StDone;
                        end
                    end
                end
                StDone: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            lfsr_q      <= INIT;
            crc_q       <= '0;
            crc_valid_q <= 1'b0;
            chk_done_q  <= 1'b0;
            crc_err_q   <= 1'b0;
            data_seen_q <= 1'b0;
            chk_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            crc_q       <= crc_d;
            crc_valid_q <= crc_valid_d;
            chk_done_q  <= chk_done_d;
            crc_err_q   <= crc_err_d;
            data_seen_q <= data_seen_d;
            chk_cnt_q   <= chk_cnt_d;
        end
    end

    assign crc       = crc_q;
    assign crc_valid = crc_valid_q;
    assign chk_done  = chk_done_q;
    assign crc_err   = crc_err_q;

endmodule

// File: tb/tb_crc_lfsr_engine.sv
// Bench for crc_lfsr_engine: directed CAN CRC-15 / CRC-17 cases plus random frames
// scored every cycle against a frame-level model built on a bit-list CRC function.
module tb_crc_lfsr_engine;

    logic        clk;
    logic        rst_n;
    logic        a_din, a_clr, a_en, a_chk;
    logic [14:0] a_crc;
    logic        a_valid, a_done, a_err;
    logic        b_din, b_clr, b_en, b_chk;
    logic [16:0] b_crc;
    logic        b_valid, b_done, b_err;

    int n_cmp;
    int n_fail;
    int done_cnt;

    crc_lfsr_engine dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (a_din),
        .crc_clr  (a_clr),
        .crc_en   (a_en),
        .chk_en   (a_chk),
        .crc      (a_crc),
        .crc_valid(a_valid),
        .chk_done (a_done),
        .crc_err  (a_err)
    );

    crc_lfsr_engine #(
        .CRC_W(17),
        .POLY (17'h1685B),
        .INIT (17'h0)
    ) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (b_din),
        .crc_clr  (b_clr),
        .crc_en   (b_en),
        .chk_en   (b_chk),
        .crc      (b_crc),
        .crc_valid(b_valid),
        .chk_done (b_done),
        .crc_err  (b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Remainder of the bit string (INIT preloaded) modulo the generator polynomial.
    function automatic logic [31:0] crc_of(input bit bits[$], input int w,
                                           input logic [31:0] poly);
        logic [31:0] r;
        logic [31:0] mask;
        r    = 32'h0;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        foreach (bits[i]) begin
            if ((bits[i] ^ r[w-1]) != 1'b0) r = ((r << 1) & mask) ^ poly;
            else                            r = (r << 1) & mask;
        end
        return r;
    endfunction

    // Frame-level model of DUT A: phase 0 idle, 1 collecting data, 2 checking, 3 finished.
    int          m_phase;
    bit          m_bits[$];
    bit          m_seen;
    int          m_nchk;
    logic [31:0] m_crc;
    logic        m_valid, m_done, m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_bits.delete();
            m_seen  = 1'b0;
            m_nchk  = 0;
            m_crc   = 32'h0;
            m_valid = 1'b0;
            m_done  = 1'b0;
            m_err   = 1'b0;
        end else begin
            m_done = 1'b0;
            if (a_clr) begin
                m_phase = 1;
                m_bits.delete();
                m_seen  = 1'b0;
                m_nchk  = 0;
                m_valid = 1'b0;
                m_err   = 1'b0;
            end else if (m_phase == 1) begin
                if (a_chk) begin
                    if (!m_valid) begin
                        m_crc   = crc_of(m_bits, 15, 32'h4599);
                        m_valid = 1'b1;
                    end
                    m_bits.push_back(a_din);
                    m_nchk  = 1;
                    m_phase = 2;
                end else if (a_en) begin
                    m_bits.push_back(a_din);
                    m_seen = 1'b1;
                end else if (m_seen && !m_valid) begin
                    m_crc   = crc_of(m_bits, 15, 32'h4599);
                    m_valid = 1'b1;
                end
            end else if (m_phase == 2 && a_chk) begin
                m_bits.push_back(a_din);
                m_nchk++;
                if (m_nchk == 15) begin
                    m_done  = 1'b1;
                    m_err   = (crc_of(m_bits, 15, 32'h4599) != 32'h0);
                    m_phase = 3;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        check("model crc", {17'h0, a_crc}, m_crc);
        check("model crc_valid", {31'h0, a_valid}, {31'h0, m_valid});
        check("model chk_done", {31'h0, a_done}, {31'h0, m_done});
        check("model crc_err", {31'h0, a_err}, {31'h0, m_err});
    endtask

    // One clock of DUT A: inputs applied now, outputs compared at the next falling edge.
    task automatic cyc(input logic clr, input logic en, input logic chk, input logic d);
        a_clr = clr;
        a_en  = en;
        a_chk = chk;
        a_din = d;
        @(negedge clk);
        if (a_done) done_cnt++;
        cmp_model();
    endtask

    task automatic cyc_b(input logic clr, input logic en, input logic chk, input logic d);
        b_clr = clr;
        b_en  = en;
        b_chk = chk;
        b_din = d;
        @(negedge clk);
    endtask

    function automatic logic rbit();
        return logic'($urandom_range(0, 1));
    endfunction

    // Feed a 15-bit value MSB first as check bits, idling before positions g1 and g2.
    task automatic feed_chk15(input logic [14:0] v, input int g1, input int g2);
        for (int i = 14; i >= 0; i--) begin
            if (i == g1 || i == g2) cyc(1'b0, 1'b0, 1'b0, rbit());
            cyc(1'b0, 1'b0, 1'b1, v[i]);
        end
    endtask

    task automatic async_reset();
        a_clr = rbit();
        a_en  = rbit();
        a_chk = rbit();
        a_din = rbit();
        #2 rst_n = 1'b0;
        #1;
        check("async crc", {17'h0, a_crc}, 32'h0);
        check("async crc_valid", {31'h0, a_valid}, 32'h0);
        check("async chk_done", {31'h0, a_done}, 32'h0);
        check("async crc_err", {31'h0, a_err}, 32'h0);
        cyc(rbit(), rbit(), rbit(), rbit());
        cyc(rbit(), rbit(), rbit(), rbit());
        rst_n = 1'b1;
        // Idle state must ignore data and check strobes until a clear arrives.
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("idle after reset valid", {31'h0, a_valid}, 32'h0);
    endtask

    // Random frame: contiguous data, optional snapshot gap, then the true or corrupted CRC
    // with random stuff gaps, and a chance of aborting mid-check.
    task automatic rand_frame();
        bit          data[$];
        logic [14:0] c;
        int          nd;
        int          flip;
        int          abort_at;
        nd       = $urandom_range(1, 40);
        flip     = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 14) : -1;
        abort_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 14) : -1;
        cyc(1'b1, rbit(), rbit(), rbit());
        for (int i = 0; i < nd; i++) begin
            data.push_back(rbit());
            cyc(1'b0, 1'b1, 1'b0, data[i]);
        end
        if (rbit()) cyc(1'b0, 1'b0, 1'b0, rbit());
        c = 15'(crc_of(data, 15, 32'h4599));
        if (flip >= 0) c[flip] = ~c[flip];
        for (int i = 14; i >= 0; i--) begin
            while ($urandom_range(0, 4) == 0) cyc(1'b0, rbit(), 1'b0, rbit());
            if (i == abort_at) begin
                cyc(1'b1, rbit(), 1'b1, c[i]);
                break;
            end
            cyc(1'b0, rbit(), 1'b1, c[i]);
        end
        repeat ($urandom_range(0, 3)) cyc(1'b0, rbit(), rbit(), rbit());
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        done_cnt = 0;
        rst_n    = 1'b0;
        {a_clr, a_en, a_chk, a_din} = 4'b0;
        {b_clr, b_en, b_chk, b_din} = 4'b0;
        repeat (2) @(negedge clk);
        check("reset crc", {17'h0, a_crc}, 32'h0);
        check("reset crc_valid", {31'h0, a_valid}, 32'h0);
        check("reset chk_done", {31'h0, a_done}, 32'h0);
        check("reset crc_err", {31'h0, a_err}, 32'h0);
        rst_n = 1'b1;

        // Single '1' data bit gives the polynomial itself, one edge after the bit.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        check("single bit latency", {31'h0, a_valid}, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("single bit crc", {17'h0, a_crc}, 32'h4599);
        check("single bit valid", {31'h0, a_valid}, 32'h1);

        // Returning the CRC with two gaps gives zero residue and a single done pulse.
        done_cnt = 0;
        feed_chk15(15'h4599, 10, 4);
        check("pass chk_done", {31'h0, a_done}, 32'h1);
        check("pass crc_err", {31'h0, a_err}, 32'h0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        check("pass done pulse", {31'h0, a_done}, 32'h0);
        check("pass done count", done_cnt, 32'd1);
        check("pass crc stable", {17'h0, a_crc}, 32'h4599);

        // Corrupted bit 7 of the returned CRC flags an error held until the next clear.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        feed_chk15(15'h4599 ^ 15'h0080, 10, 4);
        check("fail chk_done", {31'h0, a_done}, 32'h1);
        check("fail crc_err", {31'h0, a_err}, 32'h1);
        repeat (3) cyc(1'b0, rbit(), rbit(), rbit());
        check("fail err held", {31'h0, a_err}, 32'h1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("fail err cleared", {31'h0, a_err}, 32'h0);

        // 40 zero bits, abort on the 5th check bit.
        done_cnt = 0;
        repeat (40) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, rbit());
        check("zeros crc", {17'h0, a_crc}, 32'h0);
        check("zeros valid", {31'h0, a_valid}, 32'h1);
        cyc(1'b1, 1'b0, 1'b1, rbit());
        check("abort valid", {31'h0, a_valid}, 32'h0);
        check("abort err", {31'h0, a_err}, 32'h0);
        repeat (16) cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("abort no done", done_cnt, 32'd0);

        // CAN FD CRC-17 instance.
        cyc_b(1'b1, 1'b0, 1'b0, 1'b0);
        cyc_b(1'b0, 1'b1, 1'b0, 1'b1);
        cyc_b(1'b0, 1'b0, 1'b0, 1'b0);
        check("crc17 single bit", {15'h0, b_crc}, 32'h1685B);
        check("crc17 valid", {31'h0, b_valid}, 32'h1);
        begin
            logic [16:0] v;
            v = 17'h1685B;
            for (int i = 16; i >= 0; i--) begin
                if (i == 0) check("crc17 no early done", {31'h0, b_done}, 32'h0);
                cyc_b(1'b0, 1'b0, 1'b1, v[i]);
            end
        end
        check("crc17 chk_done", {31'h0, b_done}, 32'h1);
        check("crc17 crc_err", {31'h0, b_err}, 32'h0);
        cyc_b(1'b0, 1'b0, 1'b0, 1'b0);

        for (int f = 0; f < 120; f++) begin
            rand_frame();
            if (f == 60) async_reset();
        end
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom_range(0, 39) == 0), rbit(), ($urandom_range(0, 5) == 0), rbit());
            if (i == 700) async_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
